// File: rtl/frame_mux_4p_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_mux_4p_if : ingress/egress FIFO bus of the 4-port frame mux         |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface frame_mux_4p_if;
  logic [3:0]  rx_rd;
  logic [31:0] rx_dout;
  logic [3:0]  rx_ptr_rd;
  logic [63:0] rx_ptr_dout;
  logic [3:0]  rx_ptr_empty;
  logic        sfifo_wr;
  logic [7:0]  sfifo_din;
  logic        sfifo_afull;
  logic        ptr_sfifo_wr;
  logic [19:0] ptr_sfifo_din;
  logic        ptr_sfifo_full;
  logic [15:0] drop_cnt;

  modport master (
    output rx_rd, rx_ptr_rd, sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din, drop_cnt,
    input  rx_dout, rx_ptr_dout, rx_ptr_empty, sfifo_afull, ptr_sfifo_full
  );

  modport slave (
    input  rx_rd, rx_ptr_rd, sfifo_wr, sfifo_din, ptr_sfifo_wr, ptr_sfifo_din, drop_cnt,
    output rx_dout, rx_ptr_dout, rx_ptr_empty, sfifo_afull, ptr_sfifo_full
  );
endinterface
`default_nettype wire

// File: rtl/frame_mux_4p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_mux_4p : round-robin merge of 4 MAC receive FIFOs into one FIFO    |
// | Option macro FRAME_MUX_DROP_ERR_EN drains descriptors flagged err.       |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module frame_mux_4p (
  input  wire logic      clk,
  input  wire logic      rstn,
  frame_mux_4p_if.master bus
);
  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    PTR_RD  = 6'b000010,
    PTR_LAT = 6'b000100,
    XFER    = 6'b001000,
    DRAIN   = 6'b010000,
    COMMIT  = 6'b100000
  } state_t;

  state_t      state_q, state_d;
  logic        arm_q, arm_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [10:0] len_q, len_d;
  logic [10:0] cnt_q, cnt_d;
  logic [3:0]  prert_q, prert_d;
  logic [3:0]  rx_rd_q, rx_rd_d;
  logic [3:0]  rx_ptr_rd_q, rx_ptr_rd_d;
  logic        sfifo_wr_q, sfifo_wr_d;
  logic        ptr_sfifo_wr_q, ptr_sfifo_wr_d;
  logic [19:0] ptr_sfifo_din_q, ptr_sfifo_din_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        rr_found;
  logic [1:0]  rr_pick;
  logic [1:0]  rr_idx;
  logic [15:0] desc;
  logic        err_drop;
  logic        drop_inc;
  logic [3:0]  grant_oh;

  assign desc     = bus.rx_ptr_dout[{grant_q, 4'b0000} +: 16];
  assign grant_oh = 4'b0001 << grant_q;

`ifdef FRAME_MUX_DROP_ERR_EN
  assign err_drop = desc[11];
`else
  // err is deliberately ignored; the AND keeps the bit formally consumed
  assign err_drop = 1'b0 & desc[11];
`endif

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = 2'd0;
    rr_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_grant_q + 2'(i);
      if (!rr_found && !bus.rx_ptr_empty[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    arm_d           = 1'b1;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    prert_d         = prert_q;
    rx_rd_d         = 4'b0000;
    rx_ptr_rd_d     = 4'b0000;
    ptr_sfifo_wr_d  = 1'b0;
    ptr_sfifo_din_d = ptr_sfifo_din_q;
    drop_inc        = 1'b0;
    // byte data lags its read strobe by one cycle
    sfifo_wr_d      = (state_q == XFER) && (|rx_rd_q);

    unique case (state_q)
      IDLE: begin
        if (arm_q && rr_found && !bus.sfifo_afull && !bus.ptr_sfifo_full) begin
          grant_d     = rr_pick;
          rx_ptr_rd_d = 4'b0001 << rr_pick;
          state_d     = PTR_RD;
        end
      end
      PTR_RD: state_d = PTR_LAT;
      PTR_LAT: begin
        len_d   = desc[10:0];
        prert_d = desc[15:12];
        cnt_d   = 11'd1;
        if (desc[10:0] == 11'd0) begin
          drop_inc     = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (desc[10:0] < 11'd60 || desc[10:0] > 11'd1518 || err_drop) begin
          rx_rd_d = grant_oh;
          state_d = DRAIN;
        end else begin
          rx_rd_d = grant_oh;
          state_d = XFER;
        end
      end
      XFER: begin
        if (|rx_rd_q) begin
          if (cnt_q != len_q) begin
            rx_rd_d = grant_oh;
            cnt_d   = cnt_q + 11'd1;
          end
        end else begin
          // last byte is being written this cycle; descriptor follows it
          ptr_sfifo_wr_d  = 1'b1;
          ptr_sfifo_din_d = {prert_q, grant_oh, 1'b0, len_q};
          state_d         = COMMIT;
        end
      end
      DRAIN: begin
        if (cnt_q == len_q) begin
          drop_inc     = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          rx_rd_d = grant_oh;
          cnt_d   = cnt_q + 11'd1;
        end
      end
      COMMIT: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q         <= IDLE;
      arm_q           <= 1'b0;
      grant_q         <= 2'd0;
      last_grant_q    <= 2'd3;
      len_q           <= 11'd0;
      cnt_q           <= 11'd0;
      prert_q         <= 4'd0;
      rx_rd_q         <= 4'b0000;
      rx_ptr_rd_q     <= 4'b0000;
      sfifo_wr_q      <= 1'b0;
      ptr_sfifo_wr_q  <= 1'b0;
      ptr_sfifo_din_q <= 20'd0;
      drop_cnt_q      <= 16'd0;
    end else begin
      state_q         <= state_d;
      arm_q           <= arm_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      prert_q         <= prert_d;
      rx_rd_q         <= rx_rd_d;
      rx_ptr_rd_q     <= rx_ptr_rd_d;
      sfifo_wr_q      <= sfifo_wr_d;
      ptr_sfifo_wr_q  <= ptr_sfifo_wr_d;
      ptr_sfifo_din_q <= ptr_sfifo_din_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign bus.rx_rd         = rx_rd_q;
  assign bus.rx_ptr_rd     = rx_ptr_rd_q;
  assign bus.sfifo_wr      = sfifo_wr_q;
  assign bus.sfifo_din     = sfifo_wr_q ? bus.rx_dout[{grant_q, 3'b000} +: 8] : 8'h00;
  assign bus.ptr_sfifo_wr  = ptr_sfifo_wr_q;
  assign bus.ptr_sfifo_din = ptr_sfifo_din_q;
  assign bus.drop_cnt      = drop_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_mux_4p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_mux_4p : scoreboard bench for frame_mux_4p                      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_frame_mux_4p;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  frame_mux_4p_if bus ();
  frame_mux_4p dut (.clk(clk), .rstn(rstn), .bus(bus));

`ifdef FRAME_MUX_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  byte_q [4][$];
  logic [15:0] desc_q [4][$];
  logic [7:0]  exp_b [$];
  logic [19:0] exp_d [$];
  int          exp_drop = 0;
  int          rd_cnt [4];
  int          wr_cnt = 0, pr_cnt = 0, oh_err = 0;
  int          grant_log [$];
  logic [19:0] last_desc = 20'd0;
  logic        prev_wr = 1'b0;
  logic [15:0] pop_d;

  // Expected output of one descriptor, derived from the bench's own frame data
  function automatic void expect_frame(input int p, input logic [15:0] d);
    int len;
    bit fwd;
    len = int'(d[10:0]);
    fwd = (len >= 60) && (len <= 1518) && !(DROP_ERR && d[11]);
    if (fwd) begin
      for (int i = 0; i < len; i++) exp_b.push_back(byte_q[p][i]);
      exp_d.push_back({d[15:12], 4'(1 << p), 1'b0, d[10:0]});
    end else begin
      exp_drop++;
    end
  endfunction

  // Source FIFO model: data appears the cycle after its read strobe
  always @(negedge clk) begin
    if (!rstn) begin
      for (int p = 0; p < 4; p++) begin
        if (bus.rx_ptr_rd[p] && desc_q[p].size() > 0) begin
          pop_d = desc_q[p].pop_front();
          bus.rx_ptr_dout[p*16 +: 16] = pop_d;
          expect_frame(p, pop_d);
        end
        if (bus.rx_rd[p] && byte_q[p].size() > 0)
          bus.rx_dout[p*8 +: 8] = byte_q[p].pop_front();
      end
    end
    for (int p = 0; p < 4; p++) bus.rx_ptr_empty[p] = (desc_q[p].size() == 0);
  end

  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      for (int p = 0; p < 4; p++) if (bus.rx_rd[p]) rd_cnt[p]++;
      for (int p = 0; p < 4; p++) if (bus.rx_ptr_rd[p]) grant_log.push_back(p);
      if (|bus.rx_ptr_rd) pr_cnt++;
      if ($countones(bus.rx_rd) > 1 || $countones(bus.rx_ptr_rd) > 1) oh_err++;
      if (bus.sfifo_wr) begin
        wr_cnt++;
        chk("byte_pending", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) chk("byte", bus.sfifo_din, exp_b.pop_front());
      end
      if (bus.ptr_sfifo_wr) begin
        last_desc = bus.ptr_sfifo_din;
        chk("desc_after_last_byte", prev_wr, 1);
        chk("bytes_before_desc", exp_b.size(), 0);
        chk("desc_pending", exp_d.size() > 0, 1);
        if (exp_d.size() > 0) chk("desc", bus.ptr_sfifo_din, exp_d.pop_front());
      end
      prev_wr = bus.sfifo_wr;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic load(input int p, input int len, input logic [3:0] prert, input bit err);
    for (int i = 0; i < len; i++) byte_q[p].push_back(8'($urandom));
    desc_q[p].push_back({prert, err, 11'(len)});
  endtask

  task automatic wait_quiet(input string tag, input int max);
    int quiet;
    int n;
    bit pend;
    quiet = 0;
    n = 0;
    while (quiet < 8 && n < max) begin
      @(negedge clk);
      n++;
      pend = 1'b0;
      for (int p = 0; p < 4; p++) if (desc_q[p].size() > 0) pend = 1'b1;
      if (bus.rx_rd == 4'b0 && bus.rx_ptr_rd == 4'b0 && !bus.sfifo_wr && !bus.ptr_sfifo_wr && !pend)
        quiet++;
      else
        quiet = 0;
    end
    chk({tag, "_done"}, quiet >= 8, 1);
    chk({tag, "_sb_bytes"}, exp_b.size(), 0);
    chk({tag, "_sb_desc"}, exp_d.size(), 0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2;
    rstn = 1'b1;
    for (int p = 0; p < 4; p++) begin
      byte_q[p].delete();
      desc_q[p].delete();
    end
    exp_b.delete();
    exp_d.delete();
    exp_drop = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b0;
  endtask

  int b_wr, b_pr, b_rd1, b_rd3, b_gl, b_drop, cyc;

  initial begin
    bus.rx_dout        = 32'd0;
    bus.rx_ptr_dout    = 64'd0;
    bus.rx_ptr_empty   = 4'hF;
    bus.sfifo_afull    = 1'b0;
    bus.ptr_sfifo_full = 1'b0;
    for (int p = 0; p < 4; p++) rd_cnt[p] = 0;

    // Reset state with a frame already waiting on port 0
    load(0, 60, 4'h3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_rd", bus.rx_rd, 0);
    chk("rst_rx_ptr_rd", bus.rx_ptr_rd, 0);
    chk("rst_sfifo_wr", bus.sfifo_wr, 0);
    chk("rst_sfifo_din", bus.sfifo_din, 0);
    chk("rst_ptr_sfifo_wr", bus.ptr_sfifo_wr, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    release_reset();
    cyc = 0;
    while (bus.rx_ptr_rd == 4'b0 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("first_grant_not_before_cycle2", cyc >= 2, 1);
    chk("first_grant_port0", bus.rx_ptr_rd, 4'b0001);
    wait_quiet("post_reset", 200);

    // Single 64-byte frame on port 2
    b_wr = wr_cnt;
    load(2, 64, 4'h1, 1'b0);
    wait_quiet("p2_64", 300);
    chk("p2_64_wr_count", wr_cnt - b_wr, 64);
    chk("p2_64_desc", last_desc, 20'h14040);
    chk("p2_64_drop", bus.drop_cnt, 0);

    // All four ports after reset: grant order 0,1,2,3
    assert_reset();
    release_reset();
    b_wr = wr_cnt;
    b_gl = grant_log.size();
    for (int p = 0; p < 4; p++) load(p, 60, 4'(p + 4), 1'b0);
    wait_quiet("rr4", 800);
    chk("rr4_wr_count", wr_cnt - b_wr, 240);
    chk("rr4_grants", grant_log.size() - b_gl, 4);
    for (int k = 0; k < 4; k++)
      if (grant_log.size() > b_gl + k) chk("rr4_order", grant_log[b_gl + k], k);

    // Oversize drain then legal frame, then zero-length
    b_wr  = wr_cnt;
    b_rd1 = rd_cnt[1];
    load(1, 1519, 4'h0, 1'b0);
    load(1, 100, 4'h0, 1'b0);
    wait_quiet("p1_long", 5000);
    chk("p1_rd_count", rd_cnt[1] - b_rd1, 1619);
    chk("p1_wr_count", wr_cnt - b_wr, 100);
    chk("p1_drop", bus.drop_cnt, 1);
    b_rd3 = rd_cnt[3];
    load(3, 0, 4'h0, 1'b0);
    wait_quiet("len0", 200);
    chk("len0_rd_count", rd_cnt[3] - b_rd3, 0);
    chk("len0_drop", bus.drop_cnt, 2);
    chk("drop_vs_model", bus.drop_cnt, exp_drop);

    // Back-pressure only gates the start of a frame
    bus.sfifo_afull = 1'b1;
    b_pr = pr_cnt;
    b_wr = wr_cnt;
    load(0, 80, 4'h0, 1'b0);
    repeat (50) @(negedge clk);
    chk("afull_no_ptr_rd", pr_cnt - b_pr, 0);
    bus.sfifo_afull = 1'b0;
    cyc = 0;
    while (wr_cnt - b_wr < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("afull_started", wr_cnt - b_wr >= 10, 1);
    bus.sfifo_afull = 1'b1;
    wait_quiet("afull_mid", 400);
    chk("afull_mid_wr_count", wr_cnt - b_wr, 80);
    bus.sfifo_afull = 1'b0;
    bus.ptr_sfifo_full = 1'b1;
    b_pr = pr_cnt;
    load(3, 60, 4'h0, 1'b0);
    repeat (30) @(negedge clk);
    chk("pfull_no_ptr_rd", pr_cnt - b_pr, 0);
    bus.ptr_sfifo_full = 1'b0;
    wait_quiet("pfull_release", 300);

    // err-flagged frame: drop or forward depending on build option
    b_wr   = wr_cnt;
    b_drop = int'(bus.drop_cnt);
    load(0, 64, 4'h2, 1'b1);
    wait_quiet("err64", 300);
    chk("err64_wr_count", wr_cnt - b_wr, DROP_ERR ? 0 : 64);
    chk("err64_drop_delta", int'(bus.drop_cnt) - b_drop, DROP_ERR ? 1 : 0);
    chk("err64_desc_bit11", last_desc[11], 0);

    // Reset in the middle of a 200-byte frame
    b_rd1 = rd_cnt[1];
    load(1, 200, 4'h0, 1'b0);
    cyc = 0;
    while (rd_cnt[1] - b_rd1 < 30 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("midrst_reached_30", rd_cnt[1] - b_rd1, 30);
    assert_reset();
    @(posedge clk);
    #1;
    chk("midrst_rx_rd", bus.rx_rd, 0);
    chk("midrst_rx_ptr_rd", bus.rx_ptr_rd, 0);
    chk("midrst_sfifo_wr", bus.sfifo_wr, 0);
    chk("midrst_ptr_sfifo_wr", bus.ptr_sfifo_wr, 0);
    chk("midrst_drop", bus.drop_cnt, 0);
    release_reset();
    b_gl = grant_log.size();
    load(1, 60, 4'h0, 1'b0);
    load(0, 60, 4'h0, 1'b0);
    wait_quiet("midrst_after", 400);
    chk("midrst_grants", grant_log.size() - b_gl, 2);
    if (grant_log.size() > b_gl) chk("midrst_first_port0", grant_log[b_gl], 0);
    chk("final_drop_vs_model", bus.drop_cnt, exp_drop);
    chk("onehot_violations", oh_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
